// File: rtl/rocca_s_dbg_pkg.sv
// Shared definitions for the Rocca-S debug/CSR path: watchdog FSM encoding and default widths.
package rocca_s_dbg_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_SUSPECT = 2'b01;
    localparam logic [1:0] ST_REPORT  = 2'b10;
    localparam logic [1:0] ST_LATCHED = 2'b11;

    localparam int DEF_NUM_SIGS = 5;
    localparam int DEF_THRESH_W = 16;

endpackage

// File: rtl/rocca_s_deadlock_watchdog_if.sv
// Deadlock report port: one snapshot per confirmed deadlock, valid/ready handshake.
// Payload is held stable by the master while valid is high and ready is low.
interface rocca_s_deadlock_watchdog_if
    import rocca_s_dbg_pkg::*;
#(
    parameter int NUM_SIGS = DEF_NUM_SIGS,
    parameter int THRESH_W = DEF_THRESH_W
);
    logic                rpt_valid;
    logic                rpt_ready;
    logic [NUM_SIGS-1:0] rpt_sigs;
    logic [THRESH_W-1:0] rpt_cycles;

    modport master (
        output rpt_valid,
        output rpt_sigs,
        output rpt_cycles,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_sigs,
        input  rpt_cycles,
        output rpt_ready
    );
endinterface

// File: rtl/rocca_s_deadlock_watchdog_sat_counter.sv
// Blocked-cycle counter: load-1, increment, clear; sticks at all-ones instead of wrapping.
// One-cycle update latency; clear wins over load, load wins over increment.
module rocca_s_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q, count_d;

    assign count = count_q;
    assign sat   = &count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load1) begin
            count_d = ONE;
        end else if (inc && !sat) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rocca_s_deadlock_watchdog.sv
// Qualifies the HLS deadlock monitor flag over a programmable window, reports one snapshot
// over valid/ready (valid at cycle c+T, held until accepted) and raises a sticky irq.
module rocca_s_deadlock_watchdog
    import rocca_s_dbg_pkg::*;
#(
    parameter int NUM_SIGS = DEF_NUM_SIGS,
    parameter int THRESH_W = DEF_THRESH_W
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [THRESH_W-1:0]           threshold,
    input  logic                          monitor_block,
    input  logic [NUM_SIGS-1:0]           axis_block_sigs,
    input  logic                          inst_idle,
    input  logic                          clear,
    rocca_s_deadlock_watchdog_if.master   rpt,
    output logic                          deadlock_irq,
    output logic [1:0]                    state_o
);
    localparam logic [THRESH_W-1:0] CNT_ONE = THRESH_W'(1);

    logic [1:0]          state_q, state_d;
    logic [NUM_SIGS-1:0] snap_q, snap_d;
    logic [NUM_SIGS-1:0] rpt_sigs_q, rpt_sigs_d;
    logic [THRESH_W-1:0] rpt_cycles_q, rpt_cycles_d;
    logic                rpt_valid_q, rpt_valid_d;
    logic                irq_q, irq_d;

    logic [THRESH_W-1:0] cnt;
    logic [THRESH_W-1:0] cnt_p1;
    logic                cnt_sat, cnt_clr, cnt_load, cnt_inc;
    logic                hit, confirm;

    rocca_s_sat_counter #(.W(THRESH_W)) u_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .clr   (cnt_clr),
        .load1 (cnt_load),
        .inc   (cnt_inc),
        .count (cnt),
        .sat   (cnt_sat)
    );

    assign hit     = enable & monitor_block & ~inst_idle & (threshold != '0);
    assign cnt_p1  = cnt + CNT_ONE;
    // A saturated counter never matches, so a threshold lowered below the count never fires.
    assign confirm = !cnt_sat && (cnt_p1 == threshold);

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        rpt_sigs_d   = rpt_sigs_q;
        rpt_cycles_d = rpt_cycles_q;
        rpt_valid_d  = rpt_valid_q;
        irq_d        = irq_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;

        if (clear) begin
            state_d      = ST_IDLE;
            snap_d       = '0;
            rpt_sigs_d   = '0;
            rpt_cycles_d = '0;
            rpt_valid_d  = 1'b0;
            irq_d        = 1'b0;
            cnt_clr      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        cnt_load = 1'b1;
                        snap_d   = axis_block_sigs;
                        if (threshold == CNT_ONE) begin
                            state_d      = ST_REPORT;
                            rpt_sigs_d   = axis_block_sigs;
                            rpt_cycles_d = CNT_ONE;
                            rpt_valid_d  = 1'b1;
                            irq_d        = 1'b1;
                        end else begin
                            state_d = ST_SUSPECT;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!hit) begin
                        state_d = ST_IDLE;
                        snap_d  = '0;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        snap_d  = snap_q | axis_block_sigs;
                        if (confirm) begin
                            state_d      = ST_REPORT;
                            rpt_sigs_d   = snap_q | axis_block_sigs;
                            rpt_cycles_d = cnt_p1;
                            rpt_valid_d  = 1'b1;
                            irq_d        = 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (rpt.rpt_ready) begin
                        rpt_valid_d = 1'b0;
                        state_d     = ST_LATCHED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            rpt_sigs_q   <= '0;
            rpt_cycles_q <= '0;
            rpt_valid_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            rpt_sigs_q   <= rpt_sigs_d;
            rpt_cycles_q <= rpt_cycles_d;
            rpt_valid_q  <= rpt_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign rpt.rpt_valid  = rpt_valid_q;
    assign rpt.rpt_sigs   = rpt_sigs_q;
    assign rpt.rpt_cycles = rpt_cycles_q;
    assign deadlock_irq   = irq_q;
    assign state_o        = state_q;
endmodule
